// File: rtl/painterengine_gpu_render_scheduler.sv
// Render-job scheduler: queues blit commands in a small FIFO and runs them one
// at a time on the renderer. Each job goes through IDLE -> LOAD -> RUN -> RETIRE,
// or ends in ERROR when the renderer faults or the job times out.
module painterengine_gpu_render_scheduler #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_cmd_valid,
  output logic        o_wire_cmd_ready,
  input  logic [31:0] i_wire_cmd_src_address,
  input  logic [31:0] i_wire_cmd_dst_address,
  input  logic [31:0] i_wire_cmd_src_width,
  input  logic [31:0] i_wire_cmd_dst_width,
  input  logic [31:0] i_wire_cmd_xcount,
  input  logic [31:0] i_wire_cmd_ycount,
  input  logic        i_wire_flush,
  input  logic        i_wire_error_clear,
  output logic        o_wire_renderer_resetn,
  output logic [31:0] o_wire_src_address,
  output logic [31:0] o_wire_dst_address,
  output logic [31:0] o_wire_src_width,
  output logic [31:0] o_wire_dst_width,
  output logic [31:0] o_wire_xcount,
  output logic [31:0] o_wire_ycount,
  input  logic [31:0] i_wire_renderer_state,
  output logic        o_wire_busy,
  output logic [4:0]  o_wire_queue_count,
  output logic [31:0] o_wire_done_count,
  output logic [7:0]  o_wire_error_code,
  output logic        o_wire_irq
);

  localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
  localparam logic [4:0]  DEPTH_CNT = 5'(QUEUE_DEPTH);

  typedef struct packed {
    logic [31:0] src_address;
    logic [31:0] dst_address;
    logic [31:0] src_width;
    logic [31:0] dst_width;
    logic [31:0] xcount;
    logic [31:0] ycount;
  } cmd_t;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RETIRE, ST_ERROR} state_t;

  cmd_t             fifo_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  logic             ready_q, ready_d;
  state_t           state_q, state_d;
  logic             load_cnt_q, load_cnt_d;
  logic [31:0]      run_cnt_q, run_cnt_d;
  cmd_t             cfg_q, cfg_d;
  logic             resetn_q, resetn_d;
  logic             busy_q, busy_d;
  logic             irq_q, irq_d;
  logic [31:0]      done_count_q, done_count_d;
  logic [7:0]       error_code_q, error_code_d;
  cmd_t             cmd_in, head_cmd;
  logic             push, pop;
  logic [7:0]       rstate;
  logic             unused_state_bits;

  // Incoming command, FIFO head and push qualification (flush drops a same-cycle push)
  always_comb begin
    cmd_in   = {i_wire_cmd_src_address, i_wire_cmd_dst_address, i_wire_cmd_src_width,
                i_wire_cmd_dst_width, i_wire_cmd_xcount, i_wire_cmd_ycount};
    head_cmd = fifo_mem_q[head_q];
    push     = i_wire_cmd_valid && ready_q && !i_wire_flush;
    rstate   = i_wire_renderer_state[7:0];
    unused_state_bits = ^i_wire_renderer_state[31:8];
  end

  // Job sequencing: pop in IDLE, two-cycle LOAD, watch the renderer in RUN
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    run_cnt_d    = run_cnt_q;
    cfg_d        = cfg_q;
    error_code_d = error_code_q;
    pop          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q != 5'd0 && !i_wire_flush) begin
          pop = 1'b1;
          if (head_cmd.xcount == 32'd0 || head_cmd.ycount == 32'd0) begin
            state_d = ST_RETIRE;
          end else begin
            cfg_d      = head_cmd;
            load_cnt_d = 1'b0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_cnt_q) begin
          run_cnt_d = 32'd0;
          state_d   = ST_RUN;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        if (run_cnt_q != 32'd0 && rstate == 8'h06) begin
          state_d = ST_RETIRE;
        end else if (run_cnt_q != 32'd0 && rstate >= 8'h07 && rstate <= 8'h09) begin
          state_d      = ST_ERROR;
          error_code_d = rstate;
        end else if (TIMEOUT_CYCLES != 32'd0 && run_cnt_d == TIMEOUT_CYCLES) begin
          state_d      = ST_ERROR;
          error_code_d = 8'h0A;
        end
      end
      ST_RETIRE: state_d = ST_IDLE;
      ST_ERROR: begin
        if (i_wire_error_clear) begin
          error_code_d = 8'h00;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    resetn_d     = (state_d == ST_RUN);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
    irq_d        = (state_d == ST_RETIRE) || (state_d == ST_ERROR && state_q != ST_ERROR);
    done_count_d = done_count_q + {31'd0, (state_d == ST_RETIRE)};
  end

  // FIFO pointer and occupancy update; ready reflects the post-update count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_wire_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 5'd0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + {4'd0, push} - {4'd0, pop};
    end
    ready_d = (count_d < DEPTH_CNT);
  end

  // Command storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_wire_clock) begin
    if (push) fifo_mem_q[tail_q] <= cmd_in;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 5'd0;
      ready_q      <= 1'b0;
      state_q      <= ST_IDLE;
      load_cnt_q   <= 1'b0;
      run_cnt_q    <= 32'd0;
      cfg_q        <= '0;
      resetn_q     <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      done_count_q <= 32'd0;
      error_code_q <= 8'h00;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      run_cnt_q    <= run_cnt_d;
      cfg_q        <= cfg_d;
      resetn_q     <= resetn_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
      done_count_q <= done_count_d;
      error_code_q <= error_code_d;
    end
  end

  assign o_wire_cmd_ready       = ready_q;
  assign o_wire_renderer_resetn = resetn_q;
  assign o_wire_src_address     = cfg_q.src_address;
  assign o_wire_dst_address     = cfg_q.dst_address;
  assign o_wire_src_width       = cfg_q.src_width;
  assign o_wire_dst_width       = cfg_q.dst_width;
  assign o_wire_xcount          = cfg_q.xcount;
  assign o_wire_ycount          = cfg_q.ycount;
  assign o_wire_busy            = busy_q;
  assign o_wire_queue_count     = count_q;
  assign o_wire_done_count      = done_count_q;
  assign o_wire_error_code      = error_code_q;
  assign o_wire_irq             = irq_q;

endmodule

// File: tb/tb_painterengine_gpu_render_scheduler.sv
// Bench for the render scheduler: directed job scenarios followed by random
// traffic, all checked every cycle against a job-lifecycle reference model.
module tb_painterengine_gpu_render_scheduler;

  localparam int unsigned DEPTH       = 4;
  localparam int          TIMEOUT_INT = 120;

  typedef struct packed {
    logic [31:0] src_address;
    logic [31:0] dst_address;
    logic [31:0] src_width;
    logic [31:0] dst_width;
    logic [31:0] xcount;
    logic [31:0] ycount;
  } cmd_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0, cmd_dst = '0, cmd_sw = '0, cmd_dw = '0, cmd_x = '0, cmd_y = '0;
  logic        flush = 1'b0;
  logic        error_clear = 1'b0;
  logic        renderer_resetn;
  logic [31:0] src_address, dst_address, src_width, dst_width, xcount, ycount;
  logic [31:0] renderer_state = '0;
  logic        busy;
  logic [4:0]  queue_count;
  logic [31:0] done_count;
  logic [7:0]  error_code;
  logic        irq;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: a job queue plus the lifecycle of the one job in flight
  cmd_t        mq[$];
  bit          have_job = 0, retire_now = 0, in_error = 0, m_irq = 0, m_ready = 0;
  int          job_age = 0;
  cmd_t        m_cfg = '0;
  logic [31:0] m_done = '0;
  logic [7:0]  m_err = '0;
  int          plan_k = 0;
  logic [7:0]  plan_code = 8'h06;
  int          force_k = -1;
  logic [7:0]  force_code = 8'h06;
  cmd_t        idle_cmd = '0;

  painterengine_gpu_render_scheduler #(
    .QUEUE_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(32'(TIMEOUT_INT))
  ) dut (
    .i_wire_clock(clock),
    .i_wire_reset(reset),
    .i_wire_cmd_valid(cmd_valid),
    .o_wire_cmd_ready(cmd_ready),
    .i_wire_cmd_src_address(cmd_src),
    .i_wire_cmd_dst_address(cmd_dst),
    .i_wire_cmd_src_width(cmd_sw),
    .i_wire_cmd_dst_width(cmd_dw),
    .i_wire_cmd_xcount(cmd_x),
    .i_wire_cmd_ycount(cmd_y),
    .i_wire_flush(flush),
    .i_wire_error_clear(error_clear),
    .o_wire_renderer_resetn(renderer_resetn),
    .o_wire_src_address(src_address),
    .o_wire_dst_address(dst_address),
    .o_wire_src_width(src_width),
    .o_wire_dst_width(dst_width),
    .o_wire_xcount(xcount),
    .o_wire_ycount(ycount),
    .i_wire_renderer_state(renderer_state),
    .o_wire_busy(busy),
    .o_wire_queue_count(queue_count),
    .o_wire_done_count(done_count),
    .o_wire_error_code(error_code),
    .o_wire_irq(irq)
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, actual, expected, $time);
  endtask

  // Decide when and how the renderer will finish the job just launched
  task automatic choosePlan();
    int r;
    if (force_k >= 0) begin
      plan_k    = force_k;
      plan_code = force_code;
    end else begin
      r = $urandom_range(0, 9);
      if (r <= 5)      begin plan_k = $urandom_range(2, 110); plan_code = 8'h06; end
      else if (r == 6) begin plan_k = $urandom_range(2, 110); plan_code = 8'(7 + $urandom_range(0, 2)); end
      else if (r == 7) begin plan_k = 100000; plan_code = 8'h06; end
      else if (r == 8) begin plan_k = TIMEOUT_INT; plan_code = 8'h06; end
      else             begin plan_k = 2; plan_code = 8'h06; end
    end
  endtask

  // Renderer behaviour: planned result on the planned RUN cycle, noise otherwise
  function automatic logic [31:0] pickState();
    logic [31:0] w;
    int k;
    w = $urandom;
    if (have_job && job_age >= 3) begin
      k = job_age - 2;
      if (k == plan_k) w[7:0] = plan_code;
      else if (k == 1 && w[8]) w[7:0] = w[9] ? 8'h06 : 8'h08;
      else if (w[7:0] >= 8'h06 && w[7:0] <= 8'h09) w[7:0] = 8'h03;
    end
    return w;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  task automatic modelStep();
    bit   pop, acc, entered;
    cmd_t c;
    int   k;
    logic [7:0] code;
    if (reset) begin
      mq.delete();
      have_job = 0; retire_now = 0; in_error = 0; job_age = 0;
      m_cfg = '0; m_done = '0; m_err = '0; m_irq = 0; m_ready = 0;
      return;
    end
    acc     = cmd_valid && m_ready && !flush;
    pop     = !have_job && !retire_now && !in_error && mq.size() != 0 && !flush;
    m_irq   = 0;
    entered = 0;
    if (retire_now) retire_now = 0;
    else if (in_error) begin
      if (error_clear) begin in_error = 0; m_err = 8'h00; end
    end else if (have_job) begin
      if (job_age >= 3) begin
        k    = job_age - 2;
        code = renderer_state[7:0];
        if (k > 1 && code == 8'h06) begin have_job = 0; entered = 1; end
        else if (k > 1 && code >= 8'h07 && code <= 8'h09) begin
          have_job = 0; in_error = 1; m_err = code; m_irq = 1;
        end else if (k == TIMEOUT_INT) begin
          have_job = 0; in_error = 1; m_err = 8'h0A; m_irq = 1;
        end else job_age++;
      end else job_age++;
    end else if (pop) begin
      c = mq[0];
      if (c.xcount == 0 || c.ycount == 0) entered = 1;
      else begin
        have_job = 1; job_age = 1; m_cfg = c;
        choosePlan();
      end
    end
    if (entered) begin retire_now = 1; m_done = m_done + 32'd1; m_irq = 1; end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({cmd_src, cmd_dst, cmd_sw, cmd_dw, cmd_x, cmd_y});
    end
    m_ready = (mq.size() < DEPTH);
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge
  task automatic applyStimulus(input bit valid, input cmd_t c, input bit fl, input bit clr, input bit rst);
    cmd_valid = valid;
    cmd_src = c.src_address; cmd_dst = c.dst_address;
    cmd_sw  = c.src_width;   cmd_dw  = c.dst_width;
    cmd_x   = c.xcount;      cmd_y   = c.ycount;
    flush = fl; error_clear = clr; reset = rst;
    renderer_state = pickState();
    modelStep();
    @(negedge clock);
    checkOutput("cmd_ready",   32'(cmd_ready),       32'(m_ready));
    checkOutput("resetn",      32'(renderer_resetn), 32'(have_job && job_age >= 3));
    checkOutput("busy",        32'(busy),            32'(have_job));
    checkOutput("queue_count", 32'(queue_count),     32'(mq.size()));
    checkOutput("done_count",  done_count,           m_done);
    checkOutput("error_code",  32'(error_code),      32'(m_err));
    checkOutput("irq",         32'(irq),             32'(m_irq));
    checkOutput("src_address", src_address,          m_cfg.src_address);
    checkOutput("dst_address", dst_address,          m_cfg.dst_address);
    checkOutput("src_width",   src_width,            m_cfg.src_width);
    checkOutput("dst_width",   dst_width,            m_cfg.dst_width);
    checkOutput("xcount",      xcount,               m_cfg.xcount);
    checkOutput("ycount",      ycount,               m_cfg.ycount);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, idle_cmd, 1'b0, 1'b0, 1'b0);
  endtask

  // Hold a command valid until the model says it is taken, within a bound
  task automatic pushCmd(input cmd_t c);
    bit taken;
    taken = 0;
    for (int i = 0; i < 400 && !taken; i++) begin
      taken = m_ready;
      applyStimulus(1'b1, c, 1'b0, 1'b0, 1'b0);
    end
    if (!taken) checkOutput("push_wait", 32'(taken), 32'd1);
  endtask

  function automatic cmd_t mkCmd(input int id);
    cmd_t c;
    c.src_address = 32'h1000_0000 + 32'(id) * 32'h100;
    c.dst_address = 32'h2000_0000 + 32'(id) * 32'h100;
    c.src_width   = 32'd640 + 32'(id);
    c.dst_width   = 32'd800 + 32'(id);
    c.xcount      = 32'd16 + 32'(id);
    c.ycount      = 32'd4;
    return c;
  endfunction

  // Directed scenarios, then random traffic, then the summary
  initial begin
    cmd_t c;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle_cmd, 1'b0, 1'b0, 1'b1);
    runIdle(2);

    $display("[TB] single job");
    force_k = 100; force_code = 8'h06;
    pushCmd('{32'h1000_0000, 32'h2000_0000, 32'd640, 32'd800, 32'd64, 32'd2});
    runIdle(110);

    $display("[TB] five jobs, stalled renderer");
    force_k = 60;
    for (int i = 0; i < 5; i++) pushCmd(mkCmd(i + 1));
    runIdle(340);

    $display("[TB] zero-size job");
    c = mkCmd(9); c.xcount = 32'd0;
    pushCmd(c);
    runIdle(5);

    $display("[TB] renderer error then clear");
    force_k = 30; force_code = 8'h08;
    pushCmd(mkCmd(10));
    runIdle(3);
    force_k = 20; force_code = 8'h06;
    pushCmd(mkCmd(11));
    runIdle(60);
    applyStimulus(1'b0, idle_cmd, 1'b0, 1'b1, 1'b0);
    runIdle(40);

    $display("[TB] timeout, then done on the last allowed cycle");
    force_k = 100000;
    pushCmd(mkCmd(12));
    runIdle(130);
    applyStimulus(1'b0, idle_cmd, 1'b0, 1'b1, 1'b0);
    force_k = TIMEOUT_INT; force_code = 8'h06;
    pushCmd(mkCmd(13));
    runIdle(130);

    $display("[TB] flush with one running and three queued");
    force_k = 50;
    for (int i = 0; i < 4; i++) pushCmd(mkCmd(20 + i));
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 1'b0);
    runIdle(70);

    $display("[TB] random traffic");
    force_k = -1;
    for (int i = 0; i < 3000; i++) begin
      c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) c.xcount = 32'd0;
      if ($urandom_range(0, 7) == 0) c.ycount = 32'd0;
      applyStimulus($urandom_range(0, 2) == 0, c, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
